// File: rtl/melody_sequencer.sv
// Steps a song ROM from START_ADDR to END_ADDR and drives key/gate for a tone generator.
// Optional build macro MELODY_SEQ_LOOP_EN: restart at START_ADDR at end of song instead of stopping.
module melody_sequencer #(
    parameter logic [15:0] TICK_DIV   = 16'd1000,
    parameter logic [15:0] GAP_CYCLES = 16'd100,
    parameter logic [7:0]  START_ADDR = 8'd14,
    parameter logic [7:0]  END_ADDR   = 8'd81
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] rom_data,
    output logic [7:0]  rom_addr,
    output logic [7:0]  key,
    output logic        gate,
    output logic        note_strobe,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_FINISH
    } state_t;

    localparam logic [15:0] LAST_TICK     = TICK_DIV - 16'd1;
    localparam logic [15:0] GATE_OFF_TICK = TICK_DIV - 16'd1 - GAP_CYCLES;

    state_t      state_q;
    logic [7:0]  rom_addr_q;
    logic [7:0]  key_q;
    logic [7:0]  unit_cnt_q;
    logic [15:0] tick_cnt_q;
    logic        gate_q;
    logic        note_strobe_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  fetch_dur;
    logic [7:0]  fetch_key;
    logic        note_over;
    logic        song_over;

    assign fetch_dur = rom_data[15:8];
    assign fetch_key = rom_data[7:0];

    // The GAP phase reuses tick_cnt, so a note always ends on the last tick of its last unit.
    assign note_over = ((state_q == S_PLAY) && (GAP_CYCLES == 16'd0) &&
                        (unit_cnt_q == 8'd1) && (tick_cnt_q == LAST_TICK)) ||
                       ((state_q == S_GAP) && (tick_cnt_q == LAST_TICK));

    assign song_over = (note_over && (rom_addr_q == END_ADDR)) ||
                       ((state_q == S_FETCH) && (fetch_dur == 8'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rom_addr_q    <= START_ADDR;
            key_q         <= 8'd0;
            gate_q        <= 1'b0;
            note_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tick_cnt_q    <= 16'd0;
            unit_cnt_q    <= 8'd0;
        end else begin
            note_strobe_q <= 1'b0;
            done_q        <= 1'b0;
            if (stop) begin
                state_q    <= S_IDLE;
                rom_addr_q <= START_ADDR;
                key_q      <= 8'd0;
                gate_q     <= 1'b0;
                busy_q     <= 1'b0;
                tick_cnt_q <= 16'd0;
                unit_cnt_q <= 8'd0;
            end else if (song_over) begin
`ifdef MELODY_SEQ_LOOP_EN
                state_q    <= S_FETCH;
                rom_addr_q <= START_ADDR;
                gate_q     <= 1'b0;
                done_q     <= 1'b1;
`else
                // busy falls together with the done pulse; FINISH only tidies up.
                state_q    <= S_FINISH;
                key_q      <= 8'd0;
                gate_q     <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
`endif
            end else if (note_over) begin
                state_q    <= S_FETCH;
                rom_addr_q <= rom_addr_q + 8'd1;
                gate_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q    <= S_FETCH;
                            rom_addr_q <= START_ADDR;
                            busy_q     <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        state_q       <= S_PLAY;
                        key_q         <= fetch_key;
                        gate_q        <= (fetch_key != 8'd0);
                        note_strobe_q <= 1'b1;
                        unit_cnt_q    <= fetch_dur;
                        tick_cnt_q    <= 16'd0;
                    end
                    S_PLAY: begin
                        if ((unit_cnt_q == 8'd1) && (tick_cnt_q == GATE_OFF_TICK)) begin
                            state_q    <= S_GAP;
                            gate_q     <= 1'b0;
                            tick_cnt_q <= tick_cnt_q + 16'd1;
                        end else if (tick_cnt_q == LAST_TICK) begin
                            tick_cnt_q <= 16'd0;
                            unit_cnt_q <= unit_cnt_q - 8'd1;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 16'd1;
                        end
                    end
                    S_GAP: begin
                        tick_cnt_q <= tick_cnt_q + 16'd1;
                    end
                    S_FINISH: begin
                        state_q    <= S_IDLE;
                        rom_addr_q <= START_ADDR;
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        rom_addr_q <= START_ADDR;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr    = rom_addr_q;
    assign key         = key_q;
    assign gate        = gate_q;
    assign note_strobe = note_strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer: directed and random songs checked against a timeline model.
module tb_melody_sequencer;

    localparam logic [15:0] TD  = 16'd4;
    localparam logic [15:0] GAP = 16'd1;
    localparam logic [7:0]  SA  = 8'd14;
    localparam logic [7:0]  EA  = 8'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] rom_data;
    logic [7:0]  rom_addr;
    logic [7:0]  key;
    logic        gate;
    logic        note_strobe;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:255];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    melody_sequencer #(
        .TICK_DIV  (TD),
        .GAP_CYCLES(GAP),
        .START_ADDR(SA),
        .END_ADDR  (EA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .key        (key),
        .gate       (gate),
        .note_strobe(note_strobe),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] key;
        logic       gate;
        logic       strobe;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   busy_cnt, done_cnt, strobe_cnt;

    function automatic obs_t observe();
        obs_t o;
        o = {rom_addr, key, gate, note_strobe, busy, done};
        return o;
    endfunction

    function automatic obs_t mk(input logic [7:0] a, input logic [7:0] k,
                                input logic g, input logic s, input logic b, input logic d);
        obs_t o;
        o = {a, k, g, s, b, d};
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    // Expected per-cycle outputs from the cycle after start is sampled: each entry is one
    // fetch cycle followed by dur*TD cycles, gate high for all but the last GAP cycles.
    task automatic build_expected(input int idle_tail);
        logic [7:0] a;
        logic [7:0] prev_key;
        logic [7:0] dur;
        logic [7:0] k;
        int         len;
        exp_q.delete();
        a = SA;
        prev_key = 8'd0;
        while (1) begin
            exp_q.push_back(mk(a, prev_key, 1'b0, 1'b0, 1'b1, 1'b0));
            dur = rom[a][15:8];
            k   = rom[a][7:0];
            if (dur == 8'd0) begin
                exp_q.push_back(mk(a, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                break;
            end
            len = int'(dur) * int'(TD);
            for (int i = 0; i < len; i++)
                exp_q.push_back(mk(a, k, (k != 8'd0) && (i < len - int'(GAP)), i == 0, 1'b1, 1'b0));
            prev_key = k;
            if (a == EA) begin
                exp_q.push_back(mk(a, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                break;
            end
            a = a + 8'd1;
        end
        for (int i = 0; i < idle_tail; i++)
            exp_q.push_back(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic run_trace(input string tag, input bit hold_start);
        obs_t o;
        busy_cnt = 0;
        done_cnt = 0;
        strobe_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        foreach (exp_q[j]) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            o = observe();
            busy_cnt   += int'(o.busy);
            done_cnt   += int'(o.done);
            strobe_cnt += int'(o.strobe);
            check($sformatf("%s c%0d", tag, j + 1), 32'(o), 32'(exp_q[j]));
        end
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'(($urandom_range(1, 3) << 8) | $urandom_range(1, 127));
        rom[14] = {8'd1, 8'd51};
        rom[15] = {8'd2, 8'd0};

        repeat (2) @(negedge clk);
        check("reset outputs", 32'(observe()), 32'(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", 32'(observe()), 32'(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));

`ifdef MELODY_SEQ_LOOP_EN
        begin
            int ph;
            @(negedge clk);
            start = 1'b1;
            for (int c = 1; c <= 45; c++) begin
                @(negedge clk);
                start = 1'b0;
                ph = (c - 1) % 14;
                check($sformatf("loop c%0d", c), {22'd0, rom_addr, busy, done},
                      {22'd0, (ph < 5) ? SA : EA, 1'b1, (c > 1) && (ph == 0)});
            end
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            check("loop stop", 32'(observe()), 32'(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        end
`else
        // Single pass of the reference song.
        build_expected(3);
        run_trace("pass", 1'b0);
        check("pass busy_time", 32'(busy_cnt), 32'd14);
        check("pass done_cnt", 32'(done_cnt), 32'd1);
        check("pass strobe_cnt", 32'(strobe_cnt), 32'd2);

        rom[14] = {8'd3, 8'd60};
        build_expected(2);
        run_trace("long", 1'b0);

        rom[14] = {8'd0, 8'd51};
        build_expected(2);
        run_trace("term", 1'b0);
        check("term strobe_cnt", 32'(strobe_cnt), 32'd0);
        check("term done_cnt", 32'(done_cnt), 32'd1);

        for (int it = 0; it < 8; it++) begin
            rom[14] = {8'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 127))};
            rom[15] = {8'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 127))};
            build_expected(2);
            run_trace($sformatf("rand%0d", it), 1'b0);
        end

        // Held start retriggers one idle cycle after the song ends.
        rom[14] = {8'd1, 8'd51};
        rom[15] = {8'd2, 8'd0};
        build_expected(1);
        exp_q.push_back(mk(SA, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        run_trace("retrig", 1'b1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("retrig stop", 32'(observe()), 32'(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));

        // Abort during key 51, with an ignored start while playing.
        build_expected(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort c1", 32'(observe()), 32'(exp_q[0]));
        @(negedge clk);
        check("abort c2", 32'(observe()), 32'(exp_q[1]));
        start = 1'b1;
        @(negedge clk);
        check("abort c3 start ignored", 32'(observe()), 32'(exp_q[2]));
        start = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("abort idle", 32'(observe()), 32'(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            done_cnt += int'(done) + int'(busy);
        end
        check("abort quiet", 32'(done_cnt), 32'd0);

        // stop beats start in the same cycle.
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check("start+stop", 32'(observe()), 32'(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));

        // Asynchronous reset in the middle of a note.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst pre gate", {31'd0, gate}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst async", 32'(observe()), 32'(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        check("rst held", 32'(observe()), 32'(mk(SA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        rst_n = 1'b1;
        build_expected(2);
        run_trace("replay", 1'b0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
